gx4000_joy_ports: RTL and testbench
===================================

# gx4000_joy_ports

Parametrised Plus-mode controller port block for the GX4000/Amstrad Plus I/O space: synchronises and debounces up to four digital controller ports, adds per-port autofire on Fire 1, and exposes a control register, a sticky change-status register and one data register per port at a configurable I/O base. It is the multi-port successor to the two-port joystick register file. It sits on the CPU I/O decode path beside the other Plus-mode register blocks. Its `io_dout` is muxed into the CPU read bus.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of controller ports, legal range 2..4.
- `BTN_W`, 7: buttons per port. Bit order: 0 Up, 1 Down, 2 Left, 3 Right, 4 Fire1, 5 Fire2, 6 Fire3. Legal range 5..7.
- `DEBOUNCE_CYCLES`, 16: stability window in clk_sys cycles. A value of 0 bypasses debouncing.
- `AUTOFIRE_DIV`, 4096: autofire half-period in clk_sys cycles, must be ≥2.
- `BASE_ADDR`, 8'h70: I/O base, compared against `cpu_addr[7:0]`.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: reset. It is synchronous and active-high, and applies to all state.
- `plus_mode` in 1: block enable. When low, writes are ignored, read side effects are suppressed, and `io_dout` is 8'hFF.
- `cpu_addr` in 16: CPU address; only bits [7:0] are decoded.
- `cpu_data` in 8: write data.
- `cpu_wr` in 1: write strobe, sampled on each cycle it is high.
- `cpu_rd` in 1: read strobe. Side effects occur on its rising edge only.
- `joy` in NUM_PORTS*BTN_W: raw asynchronous buttons, active-high. Port n occupies `[n*BTN_W +: BTN_W]`.
- `io_dout` out 8: read data, combinational from registered state.
- `irq_chg` out 1: high while any status bit is set.

## Operation
Register map (offsets from BASE_ADDR):
- +0 CTRL (R/W), reset 8'h00.
  - bit0 SWAP: ports 0 and 1 are exchanged in the read mux.
  - bit1 DB_EN: debounce enable. When clear, the synchronised value passes straight to the stable register.
  - bits[7:4] AF_EN[n]: autofire enable for port n. Bits for n ≥ NUM_PORTS read 0 and ignore writes.
  - bits[3:2] read 0.
- +1 STATUS (R, clear-on-read). Bit n is set when the stable value of port n changes. Bits ≥ NUM_PORTS read 0.
- +2+n DATA[n] (R).
  - Low bits: the stable buttons; high bits are zero-padded.
  - Bit 4 is replaced by `stable[4] & af_phase` when AF_EN[n]=1.
  - Bit 7 is forced to 0.
- Unmapped offsets within the base..base+5 window read 8'hFF. Any address outside the window also reads 8'hFF.

Input path and debounce:
- Each port input passes through a 2-flop synchroniser, then a per-port debouncer.
- The debouncer has a counter of width `$clog2(DEBOUNCE_CYCLES+1)` and a stable register.
- The counter clears whenever the synchronised vector differs from its previous-cycle value.
- When the synchronised value has differed from stable for DEBOUNCE_CYCLES consecutive cycles, stable loads it.
- The counter saturates; it never wraps.

Autofire:
- One shared free-running prescaler counts 0..AUTOFIRE_DIV-1.
- `af_phase` toggles at each wrap.
- Reset values: prescaler 0, `af_phase` 1.

Status and events:
- STATUS clears on the rising edge of `cpu_rd` when the address is +1.
- If a port change and that clear occur in the same cycle, the set wins.
- A CTRL write and a simultaneous read of CTRL return the old value. The new value is visible on the next cycle.
- `reset` asserted mid-debounce discards any partial count. Stable registers, synchronisers, counters and STATUS all return to 0.

## Timing
- CTRL write takes effect on the edge where `cpu_wr` is high. `io_dout` reflects it one cycle later.
- Input-to-DATA latency for a clean step held constant:
  - DB_EN=1 and D=DEBOUNCE_CYCLES>0: exactly D+3 edges.
  - DB_EN=0 or D=0: exactly 3 edges.
- Glitches shorter than D cycles never reach stable.
- A STATUS bit sets on the same edge that stable changes.
- `irq_chg` is registered and follows STATUS with 0 cycles of extra lag (it is derived from STATUS flops).
- Reset values of outputs: `io_dout` is 8'hFF if `plus_mode`=0, otherwise the value selected by the mux from reset state. `irq_chg`=0.

## Structure
- Package `gx4000_joy_pkg` holds:
  - register offsets: `JOY_OFF_CTRL`=0, `JOY_OFF_STATUS`=1, `JOY_OFF_DATA`=2;
  - CTRL bit indices;
  - button bit indices.
- Sub-module `gx4000_joy_debounce`, instantiated once per port via generate. It contains the synchroniser, counter and stable register, and outputs `stable` plus a one-cycle `changed` pulse.

## Test plan
- Reset, then `plus_mode`=1, read +2 and +3 → 8'h00. Read +1 → 8'h00. `irq_chg`=0.
- DEBOUNCE_CYCLES=16, DB_EN=1:
  - Port0 Up held high → DATA0 reads 8'h01 at edge 19, not at edge 18. STATUS=8'h01 and `irq_chg`=1. Reading +1 returns 8'h01, then 8'h00.
  - A 10-cycle pulse on port1 Fire1 → DATA1 stays 8'h00 and STATUS stays 0.
- Write CTRL=8'h01 with port0=7'h10 and port1=7'h04 → +2 reads 8'h04 and +3 reads 8'h10.
- Write CTRL=8'h10, AUTOFIRE_DIV=4, hold port0 Fire1 → DATA0 bit4 alternates 1/0 every 4 cycles. Other bits are unaffected.
- A port change on the same cycle as a STATUS read edge → STATUS bit remains set afterwards.
- `plus_mode`=0: write CTRL=8'hFF, then read +0 with `plus_mode`=1 → 8'h00 (write ignored). While `plus_mode`=0, every read is 8'hFF.

Source files
------------

// File: rtl/gx4000_joy_pkg.sv
// GX4000 Plus-mode controller ports: shared offsets and bit indices.
package gx4000_joy_pkg;

  localparam logic [7:0] JOY_OFF_CTRL   = 8'd0;
  localparam logic [7:0] JOY_OFF_STATUS = 8'd1;
  localparam logic [7:0] JOY_OFF_DATA   = 8'd2;
  localparam logic [7:0] JOY_WIN        = 8'd6;

  localparam int CTRL_SWAP   = 0;
  localparam int CTRL_DB_EN  = 1;
  localparam int CTRL_AF_LSB = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FIRE1 = 4;
  localparam int BTN_FIRE2 = 5;
  localparam int BTN_FIRE3 = 6;

  function automatic logic [7:0] ctrl_mask(input int num_ports);
    logic [7:0] m;
    m = 8'h03;
    for (int n = 0; n < 4; n++)
      if (n < num_ports) m[CTRL_AF_LSB+n] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gx4000_joy_debounce.sv
// One controller port: 2-flop synchroniser, stability counter,
// stable register and a change strobe for the edge that loads it.
module gx4000_joy_debounce #(
  parameter int BTN_W           = 7,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             db_en,
  input  logic [BTN_W-1:0] raw,
  output logic [BTN_W-1:0] stable,
  output logic             changed
);
  import gx4000_joy_pkg::*;

  localparam int CW = (DEBOUNCE_CYCLES > 0) ?
    $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [BTN_W-1:0] s1, s2, prev;
  logic [BTN_W-1:0] stable_q, stable_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  always_comb begin
    stable_nxt = stable_q;
    cnt_nxt    = cnt;
    if (!db_en || DEBOUNCE_CYCLES == 0) begin
      stable_nxt = s2;
      cnt_nxt    = '0;
    end else if (s2 != prev || s2 == stable_q) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      stable_nxt = s2;
      cnt_nxt    = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      stable_q <= '0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      prev     <= s2;
      stable_q <= stable_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign stable  = stable_q;
  assign changed = (stable_nxt != stable_q);

endmodule

// File: rtl/gx4000_joy_ports.sv
// Plus-mode controller port block: debounced ports, autofire,
// CTRL / sticky STATUS / per-port DATA registers at BASE_ADDR.
module gx4000_joy_ports #(
  parameter int         NUM_PORTS       = 2,
  parameter int         BTN_W           = 7,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         AUTOFIRE_DIV    = 4096,
  parameter logic [7:0] BASE_ADDR       = 8'h70
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       plus_mode,
  input  logic [15:0]                cpu_addr,
  input  logic [7:0]                 cpu_data,
  input  logic                       cpu_wr,
  input  logic                       cpu_rd,
  input  logic [NUM_PORTS*BTN_W-1:0] joy,
  output logic [7:0]                 io_dout,
  output logic                       irq_chg
);
  import gx4000_joy_pkg::*;

  localparam int PW = $clog2(AUTOFIRE_DIV);
  localparam logic [7:0] CTRL_MASK = ctrl_mask(NUM_PORTS);
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTOFIRE_DIV - 1);

  logic [7:0]             ctrl;
  logic [3:0]             status;
  logic                   rd_q;
  logic [PW-1:0]          presc;
  logic                   af_phase;
  logic [3:0][BTN_W-1:0]  stable;
  logic [3:0]             chg;
  logic [7:0]             data [4];
  logic [7:0]             off;
  logic [1:0]             pidx;
  logic                   wr_ctrl, rd_clr;
  logic                   unused_addr;

  assign unused_addr = ^cpu_addr[15:8];
  assign off     = cpu_addr[7:0] - BASE_ADDR;
  assign wr_ctrl = plus_mode & cpu_wr & (off == JOY_OFF_CTRL);
  assign rd_clr  = plus_mode & cpu_rd & ~rd_q &
                   (off == JOY_OFF_STATUS);

  for (genvar n = 0; n < 4; n++) begin : g_port
    if (n < NUM_PORTS) begin : g_on
      gx4000_joy_debounce #(
        .BTN_W(BTN_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk_sys(clk_sys),
        .reset(reset),
        .db_en(ctrl[CTRL_DB_EN]),
        .raw(joy[n*BTN_W +: BTN_W]),
        .stable(stable[n]),
        .changed(chg[n])
      );
    end else begin : g_off
      assign stable[n] = '0;
      assign chg[n]    = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ctrl     <= '0;
      status   <= '0;
      rd_q     <= 1'b0;
      presc    <= '0;
      af_phase <= 1'b1;
    end else begin
      rd_q <= cpu_rd;
      if (wr_ctrl) ctrl <= cpu_data & CTRL_MASK;
      // a change landing on the clearing read edge survives it
      status <= (rd_clr ? 4'h0 : status) | chg;
      if (presc == PRE_LAST) begin
        presc    <= '0;
        af_phase <= ~af_phase;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign irq_chg = |status;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      data[n] = 8'(stable[n]);
      if (ctrl[CTRL_AF_LSB+n])
        data[n][BTN_FIRE1] = stable[n][BTN_FIRE1] & af_phase;
      data[n][7] = 1'b0;
    end
  end

  always_comb begin
    pidx = 2'(off - JOY_OFF_DATA);
    if (ctrl[CTRL_SWAP] && !pidx[1]) pidx[0] = ~pidx[0];
  end

  always_comb begin
    io_dout = 8'hFF;
    if (plus_mode) begin
      unique case (1'b1)
        off == JOY_OFF_CTRL:
          io_dout = ctrl;
        off == JOY_OFF_STATUS:
          io_dout = {4'h0, status};
        off >= JOY_OFF_DATA && off < JOY_WIN:
          if (int'(pidx) < NUM_PORTS) io_dout = data[pidx];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gx4000_joy_ports.sv
// Directed scoreboard bench for gx4000_joy_ports
// (2 ports, 16-cycle debounce, autofire half-period 4).
module tb_gx4000_joy_ports;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        plus_mode = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [13:0] joy = '0;
  logic [7:0]  io_dout;
  logic        irq_chg;

  int checks = 0;
  int errors = 0;
  int edges = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  gx4000_joy_ports #(
    .NUM_PORTS(2),
    .BTN_W(7),
    .DEBOUNCE_CYCLES(16),
    .AUTOFIRE_DIV(4),
    .BASE_ADDR(8'h70)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .plus_mode(plus_mode),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd),
    .joy(joy),
    .io_dout(io_dout),
    .irq_chg(irq_chg)
  );

  always #5 clk_sys = ~clk_sys;

  // cycles since reset: autofire phase model
  always @(posedge clk_sys)
    if (reset) edges <= 0;
    else edges <= edges + 1;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h required=%h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic peek(input logic [7:0] o);
    cpu_addr = {8'h00, 8'h70 + o};
    #1;
    check(io_dout);
  endtask

  task automatic rd(input logic [7:0] o);
    cpu_addr = {8'h00, 8'h70 + o};
    cpu_rd = 1'b1;
    #1;
    check(io_dout);
    tick();
    cpu_rd = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    cpu_addr = {8'h00, 8'h70 + o};
    cpu_data = d;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  initial begin
    logic ph;
    repeat (3) tick();
    push("reset_nonplus_dout", 8'hFF);
    peek(8'd2);
    push("reset_irq", 8'h00);
    check({7'b0, irq_chg});
    reset = 1'b0;
    plus_mode = 1'b1;
    tick();
    push("reset_data0", 8'h00);
    peek(8'd2);
    push("reset_data1", 8'h00);
    peek(8'd3);
    push("reset_status", 8'h00);
    rd(8'd1);

    wr(8'd0, 8'h02);
    push("lat_data0_e18", 8'h00);
    push("lat_status_e18", 8'h00);
    push("lat_data0_e19", 8'h01);
    push("lat_status_e19", 8'h01);
    push("lat_irq_e19", 8'h01);
    joy[0] = 1'b1;
    repeat (18) tick();
    peek(8'd2);
    peek(8'd1);
    tick();
    peek(8'd2);
    peek(8'd1);
    check({7'b0, irq_chg});
    push("status_read1", 8'h01);
    rd(8'd1);
    push("status_read2", 8'h00);
    rd(8'd1);
    push("irq_cleared", 8'h00);
    check({7'b0, irq_chg});

    push("glitch_data1", 8'h00);
    push("glitch_status", 8'h00);
    joy[11] = 1'b1;
    repeat (10) tick();
    joy[11] = 1'b0;
    repeat (25) tick();
    peek(8'd3);
    peek(8'd1);

    wr(8'd0, 8'h01);
    joy = {7'h04, 7'h10};
    repeat (4) tick();
    push("swap_ctrl", 8'h01);
    peek(8'd0);
    push("swap_data0_slot", 8'h04);
    peek(8'd2);
    tick();
    push("swap_data1_slot", 8'h10);
    peek(8'd3);

    wr(8'd0, 8'hFF);
    push("ctrl_mask", 8'h33);
    peek(8'd0);
    tick();
    cpu_data = 8'h10;
    cpu_wr = 1'b1;
    #1;
    push("ctrl_wr_rd_old", 8'h33);
    check(io_dout);
    tick();
    cpu_wr = 1'b0;
    push("ctrl_wr_rd_new", 8'h10);
    peek(8'd0);

    joy[6:0] = 7'h11;
    repeat (4) tick();
    for (int i = 0; i < 12; i++) begin
      ph = ((edges >> 2) & 1) == 0;
      push("af_data0", {3'b000, ph, 4'h1});
      peek(8'd2);
      tick();
    end
    push("af_data1_plain", 8'h04);
    peek(8'd3);

    wr(8'd0, 8'h00);
    push("status_accum", 8'h03);
    rd(8'd1);
    push("status_empty", 8'h00);
    peek(8'd1);
    joy[13:7] = 7'h05;
    tick();
    tick();
    cpu_addr = 16'h0071;
    cpu_rd = 1'b1;
    #1;
    push("setclr_before", 8'h00);
    check(io_dout);
    tick();
    cpu_rd = 1'b0;
    push("setclr_after", 8'h02);
    peek(8'd1);
    push("setclr_irq", 8'h01);
    check({7'b0, irq_chg});
    tick();
    push("setclr_read", 8'h02);
    rd(8'd1);

    plus_mode = 1'b0;
    wr(8'd0, 8'hFF);
    push("off_ctrl", 8'hFF);
    peek(8'd0);
    tick();
    push("off_status", 8'hFF);
    peek(8'd1);
    tick();
    push("off_data0", 8'hFF);
    peek(8'd2);
    plus_mode = 1'b1;
    tick();
    push("off_wr_ignored", 8'h00);
    peek(8'd0);
    tick();
    push("unmapped_port2", 8'hFF);
    peek(8'd4);
    tick();
    push("outside_above", 8'hFF);
    peek(8'd6);
    tick();
    push("outside_below", 8'hFF);
    peek(8'hFF);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d required=0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
